pe_mac_acc: RTL and testbench

- Parametrised successor to the basic MAC processing element; one systolic-array cell with a configurable accumulator.
- Adds a valid/first/last beat protocol, unsigned or signed operands, a wide accumulator with overflow flag, and registered activation/weight forwarding to the neighbouring cell.
- Produces one result per first..last group of beats. Sits in a row/column of identical PEs feeding the array output collector.

---
 rtl/pe_mac_acc_if.sv | 37 +++
 rtl/pe_mac_acc.sv | 111 +++++++++++
 tb/tb_pe_mac_acc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pe_mac_acc_if.sv
// pe_mac_acc_if: beat, forwarding and result signals of one systolic MAC cell.
//   i_valid/i_first/i_last  beat qualifier and group delimiters
//   i_activation/i_weight   operands (BW bits)
//   o_activation/o_weight   operands delayed one cycle for the neighbour cell
//   o_fwd_valid             i_valid delayed one cycle
//   o_result                completed group sum (ACC_W bits), held between pulses
//   o_result_valid          one-cycle pulse when o_result updates
//   o_overflow              overflow status of the group in o_result
// modport slave is the PE side; modport master is the feeder/collector side.
interface pe_mac_acc_if #(
  parameter int BW    = 8,
  parameter int ACC_W = 2*BW+8
);
  logic             i_valid;
  logic             i_first;
  logic             i_last;
  logic [BW-1:0]    i_activation;
  logic [BW-1:0]    i_weight;
  logic [BW-1:0]    o_activation;
  logic [BW-1:0]    o_weight;
  logic             o_fwd_valid;
  logic [ACC_W-1:0] o_result;
  logic             o_result_valid;
  logic             o_overflow;

  modport slave (
    input  i_valid, i_first, i_last, i_activation, i_weight,
    output o_activation, o_weight, o_fwd_valid,
    output o_result, o_result_valid, o_overflow
  );

  modport master (
    output i_valid, i_first, i_last, i_activation, i_weight,
    input  o_activation, o_weight, o_fwd_valid,
    input  o_result, o_result_valid, o_overflow
  );
endinterface

// File: rtl/pe_mac_acc.sv
// pe_mac_acc: one systolic-array MAC cell with a configurable accumulator.
// Beats are registered (stage 1) and forwarded to the neighbour; the next edge
// multiplies and accumulates (stage 2). A first..last group yields one result.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous, active-high reset
//   bus      pe_mac_acc_if.slave (beat inputs, forwarding and result outputs)
// Parameters: BW operand width, ACC_W accumulator width (>= 2*BW),
//   SIGNED 0 = unsigned, 1 = two's-complement operands and accumulator.
// Optional feature: define PE_SATURATE_EN to clamp the sum on overflow
// instead of wrapping; the clamped value is carried into later beats.
module pe_mac_acc #(
  parameter int BW     = 8,
  parameter int ACC_W  = 2*BW+8,
  parameter int SIGNED = 0
) (
  input logic         i_clock,
  input logic         i_reset,
  pe_mac_acc_if.slave bus
);

  localparam int EXT_W = ACC_W - BW;

  // Stage 1: raw beat registers, also the forwarding outputs.
  logic [BW-1:0]    act_q, wt_q;
  logic             valid_q, first_q, last_q;

  // Stage 2: accumulator state and result registers.
  logic [ACC_W-1:0] acc_q, result_q;
  logic             ovf_q, result_ovf_q, result_valid_q;

  logic [ACC_W-1:0] act_ext, wt_ext, product, base, sum_wrap, sum;
  logic             carry, ovf_beat, ovf_sticky;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    // Extending both operands to ACC_W before multiplying gives the properly
    // sign- or zero-extended 2*BW-bit product directly, since that product
    // always fits in 2*BW bits.
    act_ext = (SIGNED != 0) ? {{EXT_W{act_q[BW-1]}}, act_q} : {{EXT_W{1'b0}}, act_q};
    wt_ext  = (SIGNED != 0) ? {{EXT_W{wt_q[BW-1]}},  wt_q}  : {{EXT_W{1'b0}}, wt_q};
    product = act_ext * wt_ext;
    base    = first_q ? '0 : acc_q;
    {carry, sum_wrap} = {1'b0, base} + {1'b0, product};

    if (SIGNED != 0)
      ovf_beat = (base[ACC_W-1] == product[ACC_W-1]) &&
                 (sum_wrap[ACC_W-1] != base[ACC_W-1]);
    else
      ovf_beat = carry;

    sum = sum_wrap;
`ifdef PE_SATURATE_EN
    if (ovf_beat) begin
      if (SIGNED != 0)
        sum = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        sum = '1;
    end
`endif

    ovf_sticky = (first_q ? 1'b0 : ovf_q) | ovf_beat;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      act_q          <= '0;
      wt_q           <= '0;
      valid_q        <= 1'b0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      result_q       <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      act_q          <= bus.i_activation;
      wt_q           <= bus.i_weight;
      valid_q        <= bus.i_valid;
      first_q        <= bus.i_first;
      last_q         <= bus.i_last;
      result_valid_q <= 1'b0;

      // Invalid beats leave acc/ovf untouched and ignore first/last.
      if (valid_q) begin
        if (last_q) begin
          result_q       <= sum;
          result_ovf_q   <= ovf_sticky;
          result_valid_q <= 1'b1;
          acc_q          <= '0;
          ovf_q          <= 1'b0;
        end else begin
          acc_q <= sum;
          ovf_q <= ovf_sticky;
        end
      end
    end
  end

  assign bus.o_activation   = act_q;
  assign bus.o_weight       = wt_q;
  assign bus.o_fwd_valid    = valid_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = result_valid_q;
  assign bus.o_overflow     = result_ovf_q;

endmodule

// File: tb/tb_pe_mac_acc.sv
// tb_pe_mac_acc: directed vectors for pe_mac_acc. Three cells share one
// stimulus stream: unsigned ACC_W=24, signed ACC_W=24, unsigned ACC_W=16.
// Inputs change and outputs are sampled on the falling edge of i_clock.
module tb_pe_mac_acc;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       s_valid, s_first, s_last;
  logic [7:0] s_act, s_wt;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  pe_mac_acc_if #(.BW(8), .ACC_W(24)) if_u24 ();
  pe_mac_acc_if #(.BW(8), .ACC_W(24)) if_s24 ();
  pe_mac_acc_if #(.BW(8), .ACC_W(16)) if_u16 ();

  assign if_u24.i_valid = s_valid;  assign if_s24.i_valid = s_valid;  assign if_u16.i_valid = s_valid;
  assign if_u24.i_first = s_first;  assign if_s24.i_first = s_first;  assign if_u16.i_first = s_first;
  assign if_u24.i_last  = s_last;   assign if_s24.i_last  = s_last;   assign if_u16.i_last  = s_last;
  assign if_u24.i_activation = s_act; assign if_s24.i_activation = s_act; assign if_u16.i_activation = s_act;
  assign if_u24.i_weight     = s_wt;  assign if_s24.i_weight     = s_wt;  assign if_u16.i_weight     = s_wt;

  pe_mac_acc #(.BW(8), .ACC_W(24), .SIGNED(0)) u_u24 (.i_clock(i_clock), .i_reset(i_reset), .bus(if_u24));
  pe_mac_acc #(.BW(8), .ACC_W(24), .SIGNED(1)) u_s24 (.i_clock(i_clock), .i_reset(i_reset), .bus(if_s24));
  pe_mac_acc #(.BW(8), .ACC_W(16), .SIGNED(0)) u_u16 (.i_clock(i_clock), .i_reset(i_reset), .bus(if_u16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next falling edge, then applies one beat.
  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [7:0] a, input logic [7:0] w);
    @(negedge i_clock);
    s_valid = v; s_first = f; s_last = l; s_act = a; s_wt = w;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  logic       pv, v;
  logic [7:0] pa, pw, a, w;
  logic [15:0] exp_ovf16;

  initial begin
    i_reset = 1'b1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_act = '0; s_wt = '0;

    // Reset state.
    idle(); idle();
    check("rst_result",  64'(if_u24.o_result), 64'd0);
    check("rst_rvalid",  64'(if_u24.o_result_valid), 64'd0);
    check("rst_ovf",     64'(if_u24.o_overflow), 64'd0);
    check("rst_fwd",     64'({if_u24.o_fwd_valid, if_u24.o_activation, if_u24.o_weight}), 64'd0);
    check("rst_s24",     64'({if_s24.o_result, if_s24.o_result_valid, if_s24.o_overflow}), 64'd0);
    i_reset = 1'b0;

    // Unsigned accumulate: 2*3 + 4*5 + 10*10 = 126, pulse two cycles after last.
    drive(1, 1, 0, 8'd2, 8'd3);
    drive(1, 0, 0, 8'd4, 8'd5);
    drive(1, 0, 1, 8'd10, 8'd10);
    idle();
    check("u_lat_early", 64'(if_u24.o_result_valid), 64'd0);
    idle();
    check("u_rvalid",    64'(if_u24.o_result_valid), 64'd1);
    check("u_result",    64'(if_u24.o_result), 64'd126);
    check("u_ovf",       64'(if_u24.o_overflow), 64'd0);
    idle();
    check("u_pulse_end", 64'(if_u24.o_result_valid), 64'd0);
    check("u_hold",      64'(if_u24.o_result), 64'd126);

    // Signed: -3*7 + (-128)*(-128) = 16363, then back-to-back -1*1 = -1.
    drive(1, 1, 0, 8'hFD, 8'd7);
    drive(1, 0, 1, 8'h80, 8'h80);
    drive(1, 1, 1, 8'hFF, 8'd1);
    idle();
    check("s_rvalid1",   64'(if_s24.o_result_valid), 64'd1);
    check("s_result1",   64'(if_s24.o_result), 64'd16363);
    idle();
    check("s_rvalid2",   64'(if_s24.o_result_valid), 64'd1);
    check("s_result2",   64'(if_s24.o_result), 64'hFFFFFF);
    check("s_ovf2",      64'(if_s24.o_overflow), 64'd0);
    idle();
    check("s_pulse_end", 64'(if_s24.o_result_valid), 64'd0);

    // Gaps with garbage first/last on invalid cycles: 1*1 + 2*2 = 5.
    drive(1, 1, 0, 8'd1, 8'd1);
    drive(0, 1, 1, 8'd50, 8'd50);
    drive(0, 1, 1, 8'd50, 8'd50);
    drive(0, 1, 1, 8'd50, 8'd50);
    check("g_no_pulse1", 64'(if_u24.o_result_valid), 64'd0);
    drive(1, 0, 1, 8'd2, 8'd2);
    check("g_no_pulse2", 64'(if_u24.o_result_valid), 64'd0);
    idle();
    check("g_no_pulse3", 64'(if_u24.o_result_valid), 64'd0);
    idle();
    check("g_rvalid",    64'(if_u24.o_result_valid), 64'd1);
    check("g_result",    64'(if_u24.o_result), 64'd5);

    // Overflow: 255*255*2 = 130050 wraps to 64514 in 16 bits; fits in 24 bits.
`ifdef PE_SATURATE_EN
    exp_ovf16 = 16'd65535;
`else
    exp_ovf16 = 16'd64514;
`endif
    drive(1, 1, 0, 8'd255, 8'd255);
    drive(1, 0, 1, 8'd255, 8'd255);
    idle();
    drive(1, 1, 1, 8'd1, 8'd1);
    check("o16_rvalid",  64'(if_u16.o_result_valid), 64'd1);
    check("o16_result",  64'(if_u16.o_result), 64'(exp_ovf16));
    check("o16_ovf",     64'(if_u16.o_overflow), 64'd1);
    check("o24_result",  64'(if_u24.o_result), 64'd130050);
    check("o24_ovf",     64'(if_u24.o_overflow), 64'd0);
    idle();
    idle();
    check("o16_clean",   64'(if_u16.o_result), 64'd1);
    check("o16_clr_ovf", 64'(if_u16.o_overflow), 64'd0);

    // Reset mid-group discards the partial 9*9; then 1*2 with no first = 2.
    drive(1, 1, 0, 8'd9, 8'd9);
    idle();
    i_reset = 1'b1;
    drive(1, 0, 1, 8'd1, 8'd2);
    i_reset = 1'b0;
    check("r_result0",   64'(if_u24.o_result), 64'd0);
    check("r_flags0",    64'({if_u24.o_result_valid, if_u24.o_overflow}), 64'd0);
    check("r_fwd0",      64'({if_u24.o_fwd_valid, if_u24.o_activation, if_u24.o_weight}), 64'd0);
    idle();
    check("r_no_pulse",  64'(if_u24.o_result_valid), 64'd0);
    idle();
    check("r_rvalid",    64'(if_u24.o_result_valid), 64'd1);
    check("r_result",    64'(if_u24.o_result), 64'd2);

    // Forwarding: one-cycle delay of valid/activation/weight, valid or not.
    drive(1, 0, 0, 8'h11, 8'h22);
    pv = 1'b1; pa = 8'h11; pw = 8'h22;
    for (int i = 0; i < 24; i++) begin
      v = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      w = 8'($urandom_range(0, 255));
      drive(v, 1'b0, 1'b0, a, w);
      check("fwd", 64'({if_s24.o_fwd_valid, if_s24.o_activation, if_s24.o_weight}),
            64'({pv, pa, pw}));
      pv = v; pa = a; pw = w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
